ped_request_conditioner: RTL and testbench
==========================================

Name: ped_request_conditioner

Overview:
- Upstream stage of the traffic light controller: turns a raw, bouncy, asynchronous pedestrian push-button into the clean, held Pedestrian_req level that the controller samples.
- Synchronises and debounces the button, latches one request, and holds it until the controller grants the crossing (Pedestrian_allow).
- Enforces a cooldown after each crossing; remembers one press made during cooldown.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive cycles the synchronised button must differ from the debounced value before the debounced value changes (>=1).
- COOLDOWN_CYCLES, 20, cycles spent in COOLDOWN after Pedestrian_allow falls (>=1).
- COUNT_W, 8, width of served_count (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- btn_raw  in  1  asynchronous raw push-button, 1 = pressed.
- Pedestrian_allow  in  1  crossing grant from the traffic light controller.
- Pedestrian_req  out  1  held pedestrian request to the traffic light controller.
- wait_lamp  out  1  "WAIT" indicator; 1 while a request is outstanding or deferred.
- served_count  out  COUNT_W  crossings served, saturating (PED_STATS_EN only).

Behaviour:
- Reset (reset==0 at a clk edge): sync flops, btn_db and btn_db_q = 0; debounce and cooldown counters = 0; deferred = 0; state = IDLE; Pedestrian_req = 0; wait_lamp = 0; served_count = 0.
- Synchroniser: two flops, btn_raw -> btn_s.
- Debounce:
  - If btn_s != btn_db: counter increments. On the edge where counter == DEBOUNCE_CYCLES-1, btn_db <= btn_s and counter <= 0.
  - If btn_s == btn_db: counter <= 0.
  - Counter width = $clog2(DEBOUNCE_CYCLES+1).
- press = btn_db & ~btn_db_q (btn_db_q is btn_db delayed one cycle). Release edges are ignored.
- Latency: with btn_raw held high, Pedestrian_req rises exactly DEBOUNCE_CYCLES+3 edges after the first edge that samples btn_raw = 1. A glitch shorter than DEBOUNCE_CYCLES cycles produces no press.
- FSM (Moore outputs, registered state):
  - IDLE: req=0, lamp=deferred (always 0 here).
    - press -> PENDING.
    - Pedestrian_allow is ignored (stay IDLE).
  - PENDING: req=1, lamp=1.
    - Pedestrian_allow==1 -> SERVING.
    - Further presses are ignored.
  - SERVING: req=0, lamp=0.
    - Pedestrian_allow==0 -> COOLDOWN, load cooldown counter with COOLDOWN_CYCLES-1.
  - COOLDOWN: req=0, lamp=deferred.
    - Counter decrements each cycle.
    - A press sets deferred=1.
    - At counter==0: go to PENDING if deferred or press that cycle, else IDLE. Clear deferred.
- Simultaneous events:
  - In PENDING, allow beats press.
  - In COOLDOWN, a press on the terminal cycle counts as deferred.
- Reset mid-operation: returns to IDLE with all outputs 0 on the next edge. A button held through reset deassertion produces a press after debounce.
- Pedestrian_req never toggles except through the transitions above; it is glitch-free (direct from state flops).

Optional Feature:
- Macro PED_STATS_EN.
- Defined: served_count port exists; increments by 1 on each SERVING->COOLDOWN transition; saturates at 2^COUNT_W-1; reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package tlc_ped_pkg:
  - ped_state_t enum {IDLE, PENDING, SERVING, COOLDOWN}, 2-bit encoding.
  - LED/lamp constants shared with the controller.
- Sub-module ped_debounce (synchroniser + debounce counter, parameter DEBOUNCE_CYCLES, outputs btn_db).
- The FSM, cooldown and stats stay in the top module.

Test Plan:
- DEBOUNCE=4: btn_raw 0->1 held -> Pedestrian_req=1 exactly 7 edges later, wait_lamp=1 the same cycle.
- DEBOUNCE=4: 3-cycle btn_raw pulse, then 0 -> Pedestrian_req stays 0 for 20 cycles.
- PENDING, then allow high for 15 cycles -> req=0 the cycle after allow rises; allow falls -> COOLDOWN; with COOLDOWN=6 -> IDLE after 6 cycles; served_count 0->1 (PED_STATS_EN).
- Press debounced during COOLDOWN -> wait_lamp=1 immediately; on cooldown expiry req=1 without a new press.
- reset=0 asserted while PENDING -> next edge req=0, lamp=0, state IDLE; allow pulse while IDLE -> no change.
- PED_STATS_EN, COUNT_W=2: 5 full crossing cycles -> served_count = 3 (saturated).

Source files
------------

// File: rtl/tlc_ped_pkg.sv
// -----------------------------------------------------------------------------
// tlc_ped_pkg
// Shared types and constants for the pedestrian request path of the traffic
// light controller.
//   ped_state_t : request conditioner FSM states (2-bit encoding)
//   LAMP_* / REQ_* : indicator and request levels shared with the controller
//   ped_req_of / ped_lamp_of : Moore output decode for a given state
// -----------------------------------------------------------------------------
package tlc_ped_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PENDING  = 2'b01,
        SERVING  = 2'b10,
        COOLDOWN = 2'b11
    } ped_state_t;

    localparam logic LAMP_ON  = 1'b1;
    localparam logic LAMP_OFF = 1'b0;
    localparam logic REQ_ON   = 1'b1;
    localparam logic REQ_OFF  = 1'b0;

    // Request level driven to the controller while in a given state.
    function automatic logic ped_req_of(input ped_state_t st);
        logic req;
        case (st)
            PENDING: req = REQ_ON;
            default: req = REQ_OFF;
        endcase
        return req;
    endfunction

    // WAIT lamp level for a given state; the deferred flag only shows
    // through in IDLE/COOLDOWN (it is always clear in IDLE).
    function automatic logic ped_lamp_of(input ped_state_t st, input logic deferred);
        logic lamp;
        case (st)
            PENDING:  lamp = LAMP_ON;
            SERVING:  lamp = LAMP_OFF;
            COOLDOWN: lamp = deferred;
            IDLE:     lamp = deferred;
            default:  lamp = LAMP_OFF;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/ped_request_conditioner_if.sv
// -----------------------------------------------------------------------------
// ped_request_conditioner_if
// Bundles the pedestrian button / controller handshake.
//   btn_raw          : raw asynchronous push-button (1 = pressed)
//   Pedestrian_allow : crossing grant from the controller
//   Pedestrian_req   : held request to the controller
//   wait_lamp        : WAIT indicator
//   served_count     : saturating crossings counter (only with PED_STATS_EN)
// Modports: master = button/controller side, slave = conditioner.
// Optional feature macro: PED_STATS_EN.
// -----------------------------------------------------------------------------
interface ped_request_conditioner_if #(
    parameter int COUNT_W = 8
);
    logic btn_raw;
    logic Pedestrian_allow;
    logic Pedestrian_req;
    logic wait_lamp;

`ifdef PED_STATS_EN
    logic [COUNT_W-1:0] served_count;

    modport master (
        output btn_raw,
        output Pedestrian_allow,
        input  Pedestrian_req,
        input  wait_lamp,
        input  served_count
    );

    modport slave (
        input  btn_raw,
        input  Pedestrian_allow,
        output Pedestrian_req,
        output wait_lamp,
        output served_count
    );
`else
    modport master (
        output btn_raw,
        output Pedestrian_allow,
        input  Pedestrian_req,
        input  wait_lamp
    );

    modport slave (
        input  btn_raw,
        input  Pedestrian_allow,
        output Pedestrian_req,
        output wait_lamp
    );
`endif

endinterface

// File: rtl/ped_debounce.sv
// -----------------------------------------------------------------------------
// ped_debounce
// Two-flop synchroniser followed by a consecutive-mismatch debounce counter.
// The debounced level only changes after the synchronised button has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
//   clk     : system clock, rising edge
//   reset   : synchronous, active-low
//   btn_raw : asynchronous raw button
//   btn_db  : debounced, registered button level
// -----------------------------------------------------------------------------
module ped_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_r;
    logic             btn_s;
    logic             btn_db_r;
    logic [CNT_W-1:0] cnt_r;

    assign btn_s  = sync_r[1];
    assign btn_db = btn_db_r;

    // Synchroniser chain and debounce counter; any agreement restarts the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_r   <= 2'b00;
            btn_db_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            sync_r <= {sync_r[0], btn_raw};
            if (btn_s != btn_db_r) begin
                if (cnt_r == CNT_LAST) begin
                    btn_db_r <= btn_s;
                    cnt_r    <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

endmodule

// File: rtl/ped_request_conditioner.sv
// -----------------------------------------------------------------------------
// ped_request_conditioner
// Turns a bouncy pedestrian push-button into the held Pedestrian_req level
// sampled by the traffic light controller. One request is latched and held
// until the controller grants the crossing; after the grant drops a cooldown
// runs, during which one further press is remembered and re-issued at expiry.
//   clk   : system clock, rising edge
//   reset : synchronous, active-low
//   ped   : slave modport of ped_request_conditioner_if
//           (btn_raw, Pedestrian_allow in; Pedestrian_req, wait_lamp,
//            served_count out)
// Optional feature macro: PED_STATS_EN adds the saturating served_count.
// -----------------------------------------------------------------------------
module ped_request_conditioner
    import tlc_ped_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COOLDOWN_CYCLES = 20,
    parameter int COUNT_W         = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    ped_request_conditioner_if.slave  ped
);

    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);

    logic             btn_db_s;
    logic             btn_db_q_r;
    logic             press_s;

    ped_state_t       state_r;
    ped_state_t       state_nx_s;
    logic             deferred_r;
    logic             deferred_nx_s;
    logic [CD_W-1:0]  cd_cnt_r;
    logic [CD_W-1:0]  cd_cnt_nx_s;
    logic             serve_done_s;
    logic             req_r;
    logic             lamp_r;

    ped_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (ped.btn_raw),
        .btn_db  (btn_db_s)
    );

    // Only the rising edge of the debounced level counts as a press.
    assign press_s = btn_db_s & ~btn_db_q_r;

    // Delayed copy of the debounced level for press edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_db_q_r <= 1'b0;
        end else begin
            btn_db_q_r <= btn_db_s;
        end
    end

    // Next-state, deferred-press and cooldown counter decode.
    always_comb begin
        state_nx_s    = state_r;
        deferred_nx_s = deferred_r;
        cd_cnt_nx_s   = cd_cnt_r;
        serve_done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // Grants arriving with no request outstanding are ignored.
                if (press_s) begin
                    state_nx_s = PENDING;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            PENDING: begin
                if (ped.Pedestrian_allow) begin
                    state_nx_s = SERVING;
                end else begin
                    state_nx_s = PENDING;
                end
            end
            SERVING: begin
                if (!ped.Pedestrian_allow) begin
                    state_nx_s   = COOLDOWN;
                    cd_cnt_nx_s  = CD_LOAD;
                    serve_done_s = 1'b1;
                end else begin
                    state_nx_s = SERVING;
                end
            end
            COOLDOWN: begin
                if (cd_cnt_r == {CD_W{1'b0}}) begin
                    // A press on the terminal cycle is treated as deferred.
                    if (deferred_r || press_s) begin
                        state_nx_s = PENDING;
                    end else begin
                        state_nx_s = IDLE;
                    end
                    deferred_nx_s = 1'b0;
                end else begin
                    cd_cnt_nx_s = cd_cnt_r - CD_W'(1);
                    if (press_s) begin
                        deferred_nx_s = 1'b1;
                    end else begin
                        deferred_nx_s = deferred_r;
                    end
                end
            end
            default: begin
                state_nx_s    = IDLE;
                deferred_nx_s = 1'b0;
                cd_cnt_nx_s   = {CD_W{1'b0}};
            end
        endcase
    end

    // FSM state, cooldown counter and outputs registered together so the
    // request line comes straight off a flop and cannot glitch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            deferred_r <= 1'b0;
            cd_cnt_r   <= {CD_W{1'b0}};
            req_r      <= REQ_OFF;
            lamp_r     <= LAMP_OFF;
        end else begin
            state_r    <= state_nx_s;
            deferred_r <= deferred_nx_s;
            cd_cnt_r   <= cd_cnt_nx_s;
            req_r      <= ped_req_of(state_nx_s);
            lamp_r     <= ped_lamp_of(state_nx_s, deferred_nx_s);
        end
    end

    assign ped.Pedestrian_req = req_r;
    assign ped.wait_lamp      = lamp_r;

`ifdef PED_STATS_EN
    logic [COUNT_W-1:0] served_cnt_r;

    // Saturating count of completed crossings.
    always_ff @(posedge clk) begin
        if (!reset) begin
            served_cnt_r <= {COUNT_W{1'b0}};
        end else if (serve_done_s && (served_cnt_r != {COUNT_W{1'b1}})) begin
            served_cnt_r <= served_cnt_r + COUNT_W'(1);
        end else begin
            served_cnt_r <= served_cnt_r;
        end
    end

    assign ped.served_count = served_cnt_r;
`endif

endmodule

// File: tb/tb_ped_request_conditioner.sv
// -----------------------------------------------------------------------------
// tb_ped_request_conditioner
// Directed table of input/expected-output records for the conditioner with
// DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=6, COUNT_W=2, followed by a repeated
// crossing sequence that drives the served counter into saturation.
// -----------------------------------------------------------------------------
module tb_ped_request_conditioner;

    localparam int DEB = 4;
    localparam int CD  = 6;
    localparam int CW  = 2;

    logic clk;
    logic reset;

    int checks;
    int errors;

    ped_request_conditioner_if #(.COUNT_W(CW)) ped_if ();

    ped_request_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .COOLDOWN_CYCLES (CD),
        .COUNT_W         (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ped   (ped_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  rst_n;
        logic  btn;
        logic  allow;
        int    n;
        logic  req;
        logic  lamp;
        int    cnt;
        string name;
    } vec_t;

    vec_t vecs[25];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        ped_if.btn_raw = 1'b0;
        ped_if.Pedestrian_allow = 1'b0;

        //            rst   btn   allow  n   req   lamp  cnt  name
        vecs[0]  = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b0, 0, "reset"};
        vecs[1]  = '{1'b1, 1'b1, 1'b0,  6, 1'b0, 1'b0, 0, "pre_latency"};
        vecs[2]  = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1, 0, "latency_7"};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b1, 0, "release_hold"};
        vecs[4]  = '{1'b1, 1'b0, 1'b1,  1, 1'b0, 1'b0, 0, "grant"};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 14, 1'b0, 1'b0, 0, "grant_hold"};
        vecs[6]  = '{1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1, "cool_enter"};
        vecs[7]  = '{1'b1, 1'b0, 1'b0,  5, 1'b0, 1'b0, 1, "cool_mid"};
        vecs[8]  = '{1'b1, 1'b0, 1'b0,  1, 1'b0, 1'b0, 1, "cool_exit"};
        vecs[9]  = '{1'b1, 1'b1, 1'b0,  7, 1'b1, 1'b1, 1, "press2"};
        vecs[10] = '{1'b1, 1'b0, 1'b0,  6, 1'b1, 1'b1, 1, "press2_release"};
        vecs[11] = '{1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b0, 1, "grant2"};
        vecs[12] = '{1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b0, 2, "cool2_enter"};
        vecs[13] = '{1'b1, 1'b1, 1'b0,  3, 1'b0, 1'b0, 2, "cool2_mid"};
        vecs[14] = '{1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b0, 2, "cool2_db"};
        vecs[15] = '{1'b1, 1'b1, 1'b0,  1, 1'b0, 1'b1, 2, "deferred_lamp"};
        vecs[16] = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1, 2, "deferred_req"};
        vecs[17] = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0, 0, "reset_mid"};
        vecs[18] = '{1'b1, 1'b1, 1'b1,  1, 1'b0, 1'b0, 0, "idle_allow"};
        vecs[19] = '{1'b1, 1'b1, 1'b0,  5, 1'b0, 1'b0, 0, "held_pre"};
        vecs[20] = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1, 0, "held_thru_reset"};
        vecs[21] = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b0, 0, "reset2"};
        vecs[22] = '{1'b1, 1'b1, 1'b0,  3, 1'b0, 1'b0, 0, "glitch_hi"};
        vecs[23] = '{1'b1, 1'b0, 1'b0, 20, 1'b0, 1'b0, 0, "glitch_lo"};
        vecs[24] = '{1'b1, 1'b0, 1'b0,  2, 1'b0, 1'b0, 0, "idle_quiet"};

        for (int i = 0; i < 25; i++) begin
            reset = vecs[i].rst_n;
            ped_if.btn_raw = vecs[i].btn;
            ped_if.Pedestrian_allow = vecs[i].allow;
            step(vecs[i].n);
            check({vecs[i].name, ".req"}, int'(ped_if.Pedestrian_req), int'(vecs[i].req));
            check({vecs[i].name, ".lamp"}, int'(ped_if.wait_lamp), int'(vecs[i].lamp));
`ifdef PED_STATS_EN
            check({vecs[i].name, ".cnt"}, int'(ped_if.served_count), vecs[i].cnt);
`endif
        end

        // Five full crossings from IDLE: counter must stop at 2^CW-1.
        for (int k = 0; k < 5; k++) begin
            ped_if.btn_raw = 1'b1;
            step(DEB + 3);
            check("sat_req_rise", int'(ped_if.Pedestrian_req), 1);
            ped_if.btn_raw = 1'b0;
            ped_if.Pedestrian_allow = 1'b1;
            step(1);
            check("sat_req_grant", int'(ped_if.Pedestrian_req), 0);
            ped_if.Pedestrian_allow = 1'b0;
            step(CD + 2);
            check("sat_lamp_idle", int'(ped_if.wait_lamp), 0);
`ifdef PED_STATS_EN
            check("sat_count", int'(ped_if.served_count), (k + 1 > 3) ? 3 : k + 1);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
